// File: rtl/ca_row_writer.sv
// rtl/ca_row_writer.sv - elementary cellular automaton row generator feeding a byte-wide RAM write port
// Optional `CA_WRAP_EN: toroidal row boundary; default treats cells beyond the edges as 0.
module ca_row_writer #(
  parameter int ROW_BYTES = 8,
  parameter int ROWS      = 128,
  parameter int ADDR_W    = 10
) (
  input  logic              clk50,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rule,
  output logic              busy,
  output logic              done,
  output logic              ram_clk,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data
);

  localparam int N  = 8 * ROW_BYTES;
  localparam int BW = (ROW_BYTES > 1) ? $clog2(ROW_BYTES) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [BW-1:0]     LAST_BYTE = BW'(ROW_BYTES - 1);
  localparam logic [RW-1:0]     LAST_ROW  = RW'(ROWS - 1);
  localparam logic [BW-1:0]     BYTE_ONE  = BW'(1);
  localparam logic [RW-1:0]     ROW_ONE   = RW'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [N-1:0]      SEED      = N'(1) << (N / 2);

  typedef enum logic [1:0] {IDLE, WRITE, STEP} state_t;

  state_t          state;
  logic [7:0]      rule_q;
  logic [N-1:0]    row_q;     // bit c holds cell c
  logic [N-1:0]    row_next;
  logic [N+1:0]    ext;       // ext[c+1] = cell c, with the two boundary cells on the ends
  logic [RW-1:0]   row_idx;
  logic [BW-1:0]   byte_idx;

  assign ram_clk = clk50;

  // Byte k carries cells 8k..8k+7 with the lowest-numbered cell in bit 7.
  function automatic logic [7:0] pick_byte(input logic [N-1:0] r, input logic [BW-1:0] k);
    logic [N-1:0] sh;
    logic [7:0]   b;
    sh = r >> {k, 3'b000};
    for (int j = 0; j < 8; j++) b[7-j] = sh[j];
    return b;
  endfunction

`ifdef CA_WRAP_EN
  assign ext = {row_q[0], row_q, row_q[N-1]};
`else
  assign ext = {1'b0, row_q, 1'b0};
`endif

  always_comb begin
    row_next = '0;
    for (int i = 0; i < N; i++) row_next[i] = rule_q[{ext[i], ext[i+1], ext[i+2]}];
  end

  always_ff @(posedge clk50) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ram_en   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      row_q    <= '0;
      rule_q   <= '0;
      row_idx  <= '0;
      byte_idx <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rule_q   <= rule;
            row_q    <= SEED;
            row_idx  <= '0;
            byte_idx <= '0;
            ram_addr <= '0;
            ram_data <= pick_byte(SEED, '0);
            ram_en   <= 1'b1;
            busy     <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          if (byte_idx == LAST_BYTE) begin
            ram_en <= 1'b0;
            if (row_idx == LAST_ROW) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              state <= STEP;
            end
          end else begin
            byte_idx <= byte_idx + BYTE_ONE;
            ram_addr <= ram_addr + ADDR_ONE;
            ram_data <= pick_byte(row_q, byte_idx + BYTE_ONE);
          end
        end
        STEP: begin
          // Rows are contiguous, so the next row's byte 0 follows the last address written.
          row_q    <= row_next;
          row_idx  <= row_idx + ROW_ONE;
          byte_idx <= '0;
          ram_addr <= ram_addr + ADDR_ONE;
          ram_data <= pick_byte(row_next, '0);
          ram_en   <= 1'b1;
          state    <= WRITE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ca_row_writer.sv
// tb/tb_ca_row_writer.sv - randomized self-checking bench for ca_row_writer against a cell-level model
module tb_ca_row_writer;

  localparam int ROW_BYTES = 8;
  localparam int ROWS      = 128;
  localparam int ADDR_W    = 10;
  localparam int N         = 8 * ROW_BYTES;
  localparam int DEPTH     = ROWS * ROW_BYTES;
  localparam int RUN_CYC   = DEPTH + ROWS - 1;
`ifdef CA_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic              clk50 = 1'b0;
  logic              rst, start;
  logic [7:0]        rule;
  logic              busy, done, ram_clk, ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;

  logic [7:0]   mem [DEPTH];
  logic [N-1:0] exp_rows [ROWS];
  int           n_cmp = 0;
  int           n_bad = 0;

  ca_row_writer #(.ROW_BYTES(ROW_BYTES), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
    .clk50(clk50), .rst(rst), .start(start), .rule(rule),
    .busy(busy), .done(done), .ram_clk(ram_clk), .ram_en(ram_en),
    .ram_addr(ram_addr), .ram_data(ram_data)
  );

  always #10 clk50 = ~clk50;

  always @(posedge ram_clk) if (ram_en) mem[ram_addr] <= ram_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected rows as words: cell c sits at word bit N-1-c, so byte 0 is the word's top byte.
  task automatic build_model(input logic [7:0] r);
    bit cur [N];
    bit nxt [N];
    logic [N-1:0] w;
    int lv, rv, idx;
    for (int c = 0; c < N; c++) cur[c] = (c == N / 2);
    for (int row = 0; row < ROWS; row++) begin
      w = '0;
      for (int c = 0; c < N; c++) w[N-1-c] = cur[c];
      exp_rows[row] = w;
      for (int i = 0; i < N; i++) begin
        lv  = (WRAP || i > 0)     ? int'(cur[(i - 1 + N) % N]) : 0;
        rv  = (WRAP || i < N - 1) ? int'(cur[(i + 1) % N])     : 0;
        idx = 4 * lv + 2 * int'(cur[i]) + rv;
        nxt[i] = r[idx];
      end
      cur = nxt;
    end
  endtask

  task automatic run_and_check(input logic [7:0] r, input int second_pulse);
    int en_cnt = 0, addr_err = 0, busy_cnt = 0, busy_first = 0, busy_last = 0;
    int done_cnt = 0, done_cyc = 0;
    logic [N-1:0] w;
    build_model(r);
    @(negedge clk50); start = 1'b1; rule = r;
    @(negedge clk50); start = 1'b0; rule = 8'($urandom);
    for (int cyc = 1; cyc <= RUN_CYC + 150; cyc++) begin
      start = (cyc == second_pulse);
      if (ram_en) begin
        if (int'(ram_addr) != en_cnt) addr_err++;
        en_cnt++;
      end
      if (busy) begin
        busy_cnt++;
        if (busy_first == 0) busy_first = cyc;
        busy_last = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check_eq("busy_at_done", 64'(busy), 64'd0);
      end
      @(negedge clk50);
    end
    start = 1'b0;
    check_eq("en_count", 64'(en_cnt), 64'(DEPTH));
    check_eq("addr_seq_err", 64'(addr_err), 64'd0);
    check_eq("busy_first", 64'(busy_first), 64'd1);
    check_eq("busy_last", 64'(busy_last), 64'(RUN_CYC));
    check_eq("busy_count", 64'(busy_cnt), 64'(RUN_CYC));
    check_eq("done_count", 64'(done_cnt), 64'd1);
    check_eq("done_cycle", 64'(done_cyc), 64'(RUN_CYC + 1));
    for (int row = 0; row < ROWS; row++) begin
      w = '0;
      for (int b = 0; b < ROW_BYTES; b++) w = {w[N-9:0], mem[row * ROW_BYTES + b]};
      check_eq($sformatf("rule%0d_row%0d", r, row), 64'(w), 64'(exp_rows[row]));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rule = 8'd0;
    repeat (3) @(negedge clk50);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_en", 64'(ram_en), 64'd0);
    check_eq("rst_addr", 64'(ram_addr), 64'd0);
    check_eq("rst_data", 64'(ram_data), 64'd0);
    rst = 1'b0;
    @(negedge clk50);

    run_and_check(8'd0, 0);
    check_eq("r0_addr4", 64'(mem[4]), 64'h80);

    run_and_check(8'd204, 0);
    for (int row = 0; row < ROWS; row += 37)
      check_eq($sformatf("r204_seed_row%0d", row), 64'(mem[row * ROW_BYTES + 4]), 64'h80);

    run_and_check(8'd90, 300);
    check_eq("r90_addr11", 64'(mem[11]), 64'h01);
    check_eq("r90_addr12", 64'(mem[12]), 64'h40);

    run_and_check(8'd170, 0);
    check_eq("r170_addr256", 64'(mem[256]), 64'h80);
    if (WRAP) check_eq("r170_addr271", 64'(mem[271]), 64'h01);
    else for (int a = 264; a <= 271; a++) check_eq($sformatf("r170_addr%0d", a), 64'(mem[a]), 64'h00);

    for (int k = 0; k < 3; k++) run_and_check(8'($urandom), 0);

    // Reset in the middle of a run
    @(negedge clk50); start = 1'b1; rule = 8'd30;
    @(negedge clk50); start = 1'b0;
    repeat (499) @(negedge clk50);
    rst = 1'b1;
    @(negedge clk50);
    rst = 1'b0;
    check_eq("midrst_en", 64'(ram_en), 64'd0);
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_done", 64'(done), 64'd0);
    check_eq("midrst_addr", 64'(ram_addr), 64'd0);
    repeat (5) @(negedge clk50);
    check_eq("idle_en", 64'(ram_en), 64'd0);

    run_and_check(8'($urandom), 0);
    check_eq("post_rst_seed", 64'(mem[4]), 64'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
